// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the key debouncer: FSM state encoding,
// glitch counter width, and a helper for sizing internal counters.
package key_debounce_pkg;

  // Debounce FSM states. The accepted key level is 1 in PRESSED and REL_DEB.
  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    PRESS_DEB = 2'd1,
    PRESSED   = 2'd2,
    REL_DEB   = 2'd3
  } deb_state_e;

  // Width and saturation value of the aborted-debounce counter.
  localparam int                 GLITCH_W   = 8;
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  // Bits needed to hold the values 0 .. n-1, and never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : key_debounce_pkg

// File: rtl/key_debounce_deb_counter.sv
// Clearable, saturating up-counter of parameterised width. It is used for
// both the debounce interval counter and the long-press hold counter.
// Clear has priority over increment, and the count stops at MAX_VAL.
module deb_counter #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear, hold at the ceiling, or step by one.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_VAL)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so that every
    // register samples the pre-edge values of the others.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : deb_counter

// File: rtl/key_debounce.sv
// Key debouncer placed behind the two-flop synchronizer / edge detector.
// A level change is accepted only after DEB_CYCLES stable samples; any
// bounce during that window aborts the attempt and bumps glitch_cnt.
// Accepted presses and releases produce one-cycle pulses, and a press held
// for LONG_CYCLES produces a single long_pulse. All outputs are registered.
// DEB_CYCLES must be 2 or more; LONG_CYCLES must exceed DEB_CYCLES.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int DEB_CYCLES  = 20,
  parameter int LONG_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_sync,
  input  logic                a_bothedge,
  output logic                key_level,
  output logic                press_pulse,
  output logic                release_pulse,
  output logic                long_pulse,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int                DEB_W     = cnt_width(DEB_CYCLES);
  localparam int                HOLD_W    = cnt_width(LONG_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  deb_state_e state_q, state_d;

  // Counter controls and values.
  logic              deb_clr, deb_inc;
  logic              hold_clr, hold_inc;
  logic [DEB_W-1:0]  deb_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  // Registered outputs and the once-per-press long-pulse marker.
  logic key_level_q, key_level_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic long_q, long_d;
  logic long_done_q, long_done_d;

  // Aborted-debounce counter.
  logic                glitch_inc;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;

  // Stable-sample counter for both the press and the release window.
  deb_counter #(
    .WIDTH   (DEB_W),
    .MAX_VAL (DEB_LAST)
  ) u_deb_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (deb_clr),
    .inc_i (deb_inc),
    .cnt_o (deb_cnt)
  );

  // Press duration counter; it stops at LONG_CYCLES-1 and is frozen while
  // a release is being debounced.
  deb_counter #(
    .WIDTH   (HOLD_W),
    .MAX_VAL (HOLD_LAST)
  ) u_hold_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (hold_clr),
    .inc_i (hold_inc),
    .cnt_o (hold_cnt)
  );

  // Next-state, counter control and next-output logic of the debounce FSM.
  always_comb begin
    state_d     = state_q;
    deb_clr     = 1'b0;
    deb_inc     = 1'b0;
    hold_clr    = 1'b0;
    hold_inc    = 1'b0;
    glitch_inc  = 1'b0;
    key_level_d = key_level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    long_done_d = long_done_q;

    unique case (state_q)
      RELEASED: begin
        if (a_sync) begin
          state_d = PRESS_DEB;
          deb_clr = 1'b1;
        end
      end

      PRESS_DEB: begin
        if (!a_sync || a_bothedge) begin
          // Bounce inside the press window: abandon this attempt.
          state_d    = RELEASED;
          glitch_inc = 1'b1;
        end else if (deb_cnt == DEB_LAST) begin
          state_d     = PRESSED;
          press_d     = 1'b1;
          key_level_d = 1'b1;
          hold_clr    = 1'b1;
          long_done_d = 1'b0;
        end else begin
          deb_inc = 1'b1;
        end
      end

      PRESSED: begin
        // The hold counter parks at its ceiling, so the marker keeps the
        // long pulse to a single cycle per press.
        if ((hold_cnt == HOLD_LAST) && !long_done_q) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end
        if (!a_sync) begin
          state_d = REL_DEB;
          deb_clr = 1'b1;
        end else begin
          hold_inc = 1'b1;
        end
      end

      REL_DEB: begin
        if (a_sync || a_bothedge) begin
          // Bounce inside the release window: still pressed, hold count
          // resumes from where it was frozen.
          state_d    = PRESSED;
          glitch_inc = 1'b1;
        end else if (deb_cnt == DEB_LAST) begin
          state_d     = RELEASED;
          release_d   = 1'b1;
          key_level_d = 1'b0;
        end else begin
          deb_inc = 1'b1;
        end
      end

      default: begin
        state_d = RELEASED;
      end
    endcase
  end

  // Saturating increment of the glitch counter; it never wraps.
  always_comb begin
    glitch_d = glitch_q;
    if (glitch_inc && (glitch_q != GLITCH_MAX)) begin
      glitch_d = glitch_q + GLITCH_W'(1);
    end
  end

  // FSM state register; reset abandons any debounce in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RELEASED;
    end else begin
      state_q <= state_d;
    end
  end

  // Output registers, long-pulse marker and glitch counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_level_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      long_done_q <= 1'b0;
      glitch_q    <= '0;
    end else begin
      key_level_q <= key_level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      long_done_q <= long_done_d;
      glitch_q    <= glitch_d;
    end
  end

  assign key_level     = key_level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign glitch_cnt    = glitch_q;

endmodule : key_debounce
